// File: rtl/sprite_fetch_if.sv
// sprite_fetch_if: sprite select, descriptor table and pixel address stream signals
interface sprite_fetch_if;
  logic        start;
  logic [5:0]  sprite_id;
  logic [5:0]  tbl_idx;
  logic [44:0] tbl_data;
  logic        addr_valid;
  logic        addr_ready;
  logic [24:0] addr;
  logic [9:0]  px;
  logic [9:0]  py;
  logic        last;
  logic        busy;
  logic        done;
  logic        err;
  modport master (
    output start, sprite_id, tbl_data, addr_ready,
    input  tbl_idx, addr_valid, addr, px, py, last, busy, done, err
  );
  modport slave (
    input  start, sprite_id, tbl_data, addr_ready,
    output tbl_idx, addr_valid, addr, px, py, last, busy, done, err
  );
endinterface

// File: rtl/sprite_fetch.sv
// sprite_fetch: looks up a sprite descriptor and streams its pixel addresses in raster order
module sprite_fetch #(
  parameter int MAX_ID  = 12,
  parameter int TBL_LAT = 1
) (
  input logic           clk,
  input logic           rst,
  sprite_fetch_if.slave bus
);
  localparam int CW = TBL_LAT > 1 ? $clog2(TBL_LAT) : 1;
  typedef enum logic [2:0] {IDLE, LOOKUP, LATCH, STREAM, DONE} state_t;
  state_t      state_q, state_d;
  logic [5:0]  tbl_idx_q, tbl_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [24:0] row_base_q, row_base_d;
  logic [9:0]  width_q, width_d, height_q, height_d;
  logic [9:0]  px_q, px_d, py_q, py_d, nx_px, nx_py;
  logic        last_q, last_d, err_q, err_d, eol, rej;
  always_comb begin
    rej        = bus.sprite_id > 6'(MAX_ID);
    eol        = px_q == width_q - 10'd1;
    nx_px      = eol ? 10'd0 : px_q + 10'd1;
    nx_py      = eol ? py_q + 10'd1 : py_q;
    state_d    = state_q;
    tbl_idx_d  = tbl_idx_q;
    cnt_d      = cnt_q;
    row_base_d = row_base_q;
    width_d    = width_q;
    height_d   = height_q;
    px_d       = px_q;
    py_d       = py_q;
    last_d     = last_q;
    err_d      = err_q;
    case (state_q)
      IDLE: if (bus.start) begin
        err_d     = rej;
        tbl_idx_d = rej ? tbl_idx_q : bus.sprite_id;
        cnt_d     = CW'(TBL_LAT - 1);
        state_d   = rej ? DONE : LOOKUP;
      end
      LOOKUP: begin
        cnt_d   = cnt_q - CW'(1);
        state_d = cnt_q == '0 ? LATCH : LOOKUP;
      end
      LATCH: begin
        row_base_d = bus.tbl_data[44:20];
        width_d    = bus.tbl_data[19:10];
        height_d   = bus.tbl_data[9:0];
        px_d       = '0;
        py_d       = '0;
        last_d     = width_d == 10'd1 && height_d == 10'd1;
        state_d    = (width_d == '0 || height_d == '0) ? DONE : STREAM;
      end
      STREAM: if (bus.addr_ready) begin
        if (last_q) begin
          last_d  = 1'b0;
          state_d = DONE;
        end else begin
          px_d       = nx_px;
          py_d       = nx_py;
          // row_base tracks base + py*width so the address needs only an adder
          row_base_d = eol ? row_base_q + {15'd0, width_q} : row_base_q;
          last_d     = nx_px == width_q - 10'd1 && nx_py == height_q - 10'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tbl_idx_q  <= '0;
      cnt_q      <= '0;
      row_base_q <= '0;
      width_q    <= '0;
      height_q   <= '0;
      px_q       <= '0;
      py_q       <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tbl_idx_q  <= tbl_idx_d;
      cnt_q      <= cnt_d;
      row_base_q <= row_base_d;
      width_q    <= width_d;
      height_q   <= height_d;
      px_q       <= px_d;
      py_q       <= py_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end
  assign bus.tbl_idx    = tbl_idx_q;
  assign bus.addr_valid = state_q == STREAM;
  assign bus.addr       = row_base_q + {15'd0, px_q};
  assign bus.px         = px_q;
  assign bus.py         = py_q;
  assign bus.last       = last_q;
  assign bus.busy       = state_q != IDLE;
  assign bus.done       = state_q == DONE;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_sprite_fetch.sv
// tb_sprite_fetch: directed tests of descriptor lookup, raster streaming, rejection and reset
module tb_sprite_fetch;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  sprite_fetch_if bus();
  sprite_fetch #(.MAX_ID(12), .TBL_LAT(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [44:0] mem [64];
  always @(posedge clk) bus.tbl_data <= mem[bus.tbl_idx];
  int tests, fails;
  task automatic kick(input logic [5:0] id);
    @(negedge clk);
    bus.start = 1'b1;
    bus.sprite_id = id;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.addr_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic stream(input logic [24:0] base, input int w, input int h, input bit rnd,
                        input int inj, input int stop_at, input int snap_idx,
                        output int beats, output int bad, output int unstable,
                        output logic [24:0] last_addr, output logic [44:0] snap,
                        output int done_gap, output logic done_err);
    int ex, ey, since;
    bit stalled, fin;
    logic [45:0] held;
    beats = 0; bad = 0; unstable = 0; last_addr = '0; snap = '0; done_gap = -1; done_err = 1'b0;
    ex = 0; ey = 0; since = 0; stalled = 0; fin = 0; held = '0;
    for (int cyc = 0; cyc < 40000; cyc++) begin
      bus.start = (cyc == inj);
      bus.sprite_id = 6'd3;
      if (fin) since++;
      if (bus.done) begin
        done_gap = since;
        done_err = bus.err;
        break;
      end
      if (bus.addr_valid) begin
        if (stalled && {bus.addr, bus.px, bus.py, bus.last} !== held) unstable++;
        if (bus.addr !== 25'(base + ey * w + ex) || bus.px !== 10'(ex) || bus.py !== 10'(ey) ||
            bus.last !== (ex == w - 1 && ey == h - 1)) bad++;
        if (beats == stop_at) begin
          bus.addr_ready = 1'b0;
          break;
        end
        if (beats == snap_idx) snap = {bus.addr, bus.px, bus.py};
        bus.addr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.addr_ready) begin
          beats++;
          last_addr = bus.addr;
          stalled = 0;
          if (ex == w - 1) begin ex = 0; ey++; end else ex++;
          if (ex == 0 && ey == h) fin = 1;
        end else begin
          stalled = 1;
          held = {bus.addr, bus.px, bus.py, bus.last};
        end
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    tests++; if ({bus.addr_valid, bus.last, bus.busy, bus.done, bus.err} !== 5'd0) begin fails++; $display("FAIL reset_flags: got %b want 00000", {bus.addr_valid, bus.last, bus.busy, bus.done, bus.err}); end
    tests++; if (bus.addr !== 25'd0) begin fails++; $display("FAIL reset_addr: got %0d want 0", bus.addr); end
    tests++; if ({bus.tbl_idx, bus.px, bus.py} !== 26'd0) begin fails++; $display("FAIL reset_idx_px_py: got %0d/%0d/%0d want 0/0/0", bus.tbl_idx, bus.px, bus.py); end
    rst = 1'b0;
  endtask
  task automatic test_basic();
    int lat, beats, bad, uns, gap;
    logic [24:0] la;
    logic [44:0] snap;
    logic de;
    kick(6'd0);
    wait_valid(lat);
    tests++; if (lat !== 3) begin fails++; $display("FAIL basic_latency: got %0d want 3", lat); end
    tests++; if ({bus.addr, bus.px, bus.py} !== {25'd307200, 10'd0, 10'd0}) begin fails++; $display("FAIL basic_first: got addr %0d px %0d py %0d want 307200 0 0", bus.addr, bus.px, bus.py); end
    stream(25'd307200, 64, 48, 1'b0, -1, -1, 64, beats, bad, uns, la, snap, gap, de);
    tests++; if (beats !== 3072) begin fails++; $display("FAIL basic_beats: got %0d want 3072", beats); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL basic_model: got %0d bad beats want 0", bad); end
    tests++; if (snap !== {25'd307264, 10'd0, 10'd1}) begin fails++; $display("FAIL basic_beat65: got %h want %h", snap, {25'd307264, 10'd0, 10'd1}); end
    tests++; if (la !== 25'd310271) begin fails++; $display("FAIL basic_last_addr: got %0d want 310271", la); end
    tests++; if (gap !== 1 || de !== 1'b0) begin fails++; $display("FAIL basic_done: got gap %0d err %b want 1 0", gap, de); end
    @(negedge clk);
    tests++; if ({bus.done, bus.busy} !== 2'b00) begin fails++; $display("FAIL basic_done_pulse: got done/busy %b want 00", {bus.done, bus.busy}); end
  endtask
  task automatic test_random_ready();
    int lat, beats, bad, uns, gap;
    logic [24:0] la;
    logic [44:0] snap;
    logic de;
    kick(6'd5);
    wait_valid(lat);
    tests++; if (lat !== 3) begin fails++; $display("FAIL rand_latency: got %0d want 3", lat); end
    stream(25'd357834, 60, 100, 1'b1, -1, -1, -1, beats, bad, uns, la, snap, gap, de);
    tests++; if (beats !== 6000) begin fails++; $display("FAIL rand_beats: got %0d want 6000", beats); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL rand_model: got %0d bad beats want 0", bad); end
    tests++; if (uns !== 0) begin fails++; $display("FAIL rand_stall_stable: got %0d changes want 0", uns); end
    tests++; if (la !== 25'd363833) begin fails++; $display("FAIL rand_last_addr: got %0d want 363833", la); end
    tests++; if (gap !== 1 || de !== 1'b0) begin fails++; $display("FAIL rand_done: got gap %0d err %b want 1 0", gap, de); end
    bus.addr_ready = 1'b1;
  endtask
  task automatic test_reject();
    kick(6'd13);
    tests++; if ({bus.done, bus.err, bus.addr_valid} !== 3'b110) begin fails++; $display("FAIL reject_done_err: got done/err/valid %b want 110", {bus.done, bus.err, bus.addr_valid}); end
    tests++; if (bus.tbl_idx !== 6'd5) begin fails++; $display("FAIL reject_tbl_idx: got %0d want 5", bus.tbl_idx); end
    @(negedge clk);
    tests++; if ({bus.done, bus.busy, bus.addr_valid} !== 3'b000) begin fails++; $display("FAIL reject_idle: got done/busy/valid %b want 000", {bus.done, bus.busy, bus.addr_valid}); end
  endtask
  task automatic test_zero_dim();
    logic [5:0] ids [2] = '{6'd7, 6'd12};
    logic [2:0] dn;
    bit seen;
    foreach (ids[k]) begin
      kick(ids[k]);
      seen = bus.addr_valid;
      dn[0] = bus.done;
      @(negedge clk);
      seen |= bus.addr_valid;
      dn[1] = bus.done;
      @(negedge clk);
      seen |= bus.addr_valid;
      dn[2] = bus.done;
      tests++; if (dn !== 3'b100 || bus.err !== 1'b0) begin fails++; $display("FAIL zero_dim_done id %0d: got done seq %b err %b want 100 0", ids[k], dn, bus.err); end
      tests++; if (seen !== 1'b0) begin fails++; $display("FAIL zero_dim_beats id %0d: got addr_valid 1 want 0", ids[k]); end
      @(negedge clk);
    end
  endtask
  task automatic test_start_mid_stream();
    int lat, beats, bad, uns, gap;
    logic [24:0] la;
    logic [44:0] snap;
    logic de;
    kick(6'd0);
    wait_valid(lat);
    stream(25'd307200, 64, 48, 1'b0, 100, -1, -1, beats, bad, uns, la, snap, gap, de);
    tests++; if (beats !== 3072 || bad !== 0) begin fails++; $display("FAIL mid_start_stream: got %0d beats %0d bad want 3072 0", beats, bad); end
    tests++; if (la !== 25'd310271 || gap !== 1) begin fails++; $display("FAIL mid_start_end: got last %0d gap %0d want 310271 1", la, gap); end
    tests++; if (bus.tbl_idx !== 6'd0) begin fails++; $display("FAIL mid_start_tbl_idx: got %0d want 0", bus.tbl_idx); end
    @(negedge clk);
  endtask
  task automatic test_async_reset();
    int lat, beats, bad, uns, gap;
    logic [24:0] la;
    logic [44:0] snap;
    logic de;
    kick(6'd0);
    wait_valid(lat);
    stream(25'd307200, 64, 48, 1'b0, -1, 5 * 64 + 10, -1, beats, bad, uns, la, snap, gap, de);
    tests++; if ({bus.px, bus.py, bad} !== {10'd10, 10'd5, 32'd0}) begin fails++; $display("FAIL areset_position: got px %0d py %0d bad %0d want 10 5 0", bus.px, bus.py, bad); end
    #2 rst = 1'b1;
    #1;
    tests++; if ({bus.addr_valid, bus.last, bus.busy, bus.done, bus.err} !== 5'd0) begin fails++; $display("FAIL areset_flags: got %b want 00000", {bus.addr_valid, bus.last, bus.busy, bus.done, bus.err}); end
    tests++; if ({bus.addr, bus.px, bus.py, bus.tbl_idx} !== 51'd0) begin fails++; $display("FAIL areset_data: got addr %0d px %0d py %0d idx %0d want 0", bus.addr, bus.px, bus.py, bus.tbl_idx); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL areset_no_done: got %b want 0", bus.done); end
    kick(6'd1);
    wait_valid(lat);
    tests++; if (lat !== 3 || bus.addr !== 25'd310272) begin fails++; $display("FAIL areset_restart_first: got lat %0d addr %0d want 3 310272", lat, bus.addr); end
    stream(25'd310272, 60, 64, 1'b0, -1, -1, -1, beats, bad, uns, la, snap, gap, de);
    tests++; if (beats !== 3840 || bad !== 0 || la !== 25'd314111 || gap !== 1) begin fails++; $display("FAIL areset_restart_stream: got %0d beats %0d bad last %0d gap %0d want 3840 0 314111 1", beats, bad, la, gap); end
  endtask
  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.sprite_id = '0;
    bus.addr_ready = 1'b0;
    foreach (mem[i]) mem[i] = '0;
    mem[0]  = {25'd307200, 10'd64, 10'd48};
    mem[1]  = {25'd310272, 10'd60, 10'd64};
    mem[3]  = {25'd4096, 10'd8, 10'd8};
    mem[5]  = {25'd357834, 10'd60, 10'd100};
    mem[7]  = {25'd1000, 10'd0, 10'd48};
    mem[12] = {25'd2000, 10'd16, 10'd0};
    test_reset();
    test_basic();
    test_random_ready();
    test_reject();
    test_zero_dim();
    test_start_mid_stream();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
